// File: rtl/sc_io_input_port.sv
// sc_io_input_port: synchronised, debounced switch/key input peripheral with edge capture and maskable irq
module sc_io_input_port #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  one,
    input  logic [3:0]  two,
    input  logic [3:0]  key,
    input  logic [7:0]  io_addr,
    input  logic        io_wr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        irq
);
    // bits [11:8] are the active-low keys, which idle high (released)
    localparam logic [11:0] RST_V = 12'hF00;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [11:0] raw, s1, s2, stable, stable_nxt;
    logic [CNT_W-1:0] cnt [12];
    logic [CNT_W-1:0] cnt_nxt [12];
    logic [3:0] press, clr, cap, cap_nxt, mask, mask_nxt;
    logic unused_wdata;
    assign raw = {key, two, one};
    assign unused_wdata = ^io_wdata[31:4];
    assign press = stable[11:8] & ~stable_nxt[11:8];
    assign clr = (io_wr && io_addr == 8'h0C) ? io_wdata[3:0] : 4'h0;
    assign cap_nxt = (cap & ~clr) | press;
    assign mask_nxt = (io_wr && io_addr == 8'h10) ? io_wdata[3:0] : mask;
    // per-bit debounce: accept s2 only after it has differed for DEBOUNCE_CYCLES edges
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < 12; i++) begin
            cnt_nxt[i] = (s2[i] != stable[i] && cnt[i] != LAST) ? cnt[i] + 1'b1 : '0;
            stable_nxt[i] = (s2[i] != stable[i] && cnt[i] == LAST) ? s2[i] : stable[i];
        end
    end
    // combinational register read so the CPU sees data in the same cycle
    always_comb begin
        io_rdata = {28'b0,
            io_addr == 8'h00 ? stable[3:0] :
            io_addr == 8'h04 ? stable[7:4] :
            io_addr == 8'h08 ? ~stable[11:8] :
            io_addr == 8'h0C ? cap :
            io_addr == 8'h10 ? mask : 4'h0};
    end
    // state update; a press set takes priority over a same-cycle W1C clear
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1 <= RST_V;
            s2 <= RST_V;
            stable <= RST_V;
            for (int i = 0; i < 12; i++) cnt[i] <= '0;
            cap <= 4'h0;
            mask <= 4'h0;
            irq <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            stable <= stable_nxt;
            for (int i = 0; i < 12; i++) cnt[i] <= cnt_nxt[i];
            cap <= cap_nxt;
            mask <= mask_nxt;
            irq <= |(cap_nxt & mask_nxt);
        end
    end
endmodule

// File: tb/tb_sc_io_input_port.sv
// tb_sc_io_input_port: directed scoreboard bench for sc_io_input_port
module tb_sc_io_input_port;
    logic        clock, resetn;
    logic [3:0]  one, two, key;
    logic [7:0]  io_addr;
    logic        io_wr;
    logic [31:0] io_wdata, io_rdata;
    logic        irq;
    logic        chk;
    int          n_vec = 0, n_err = 0;
    typedef struct {
        string       nm;
        logic [31:0] rd;
        logic        irq;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    sc_io_input_port #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clock(clock), .resetn(resetn), .one(one), .two(two), .key(key),
        .io_addr(io_addr), .io_wr(io_wr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // monitor: compares the DUT against the oldest expected entry on each checked cycle
    always @(negedge clock) begin
        if (chk) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty: rdata=%h irq=%b with no expected entry", io_rdata, irq);
            end else begin
                mon_e = q.pop_front();
                if (io_rdata !== mon_e.rd || irq !== mon_e.irq) begin
                    n_err++;
                    $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                             mon_e.nm, io_rdata, irq, mon_e.rd, mon_e.irq);
                end
            end
        end
    end

    task automatic cyc(input logic [7:0] a, input logic w, input logic [31:0] wd,
                       input logic c, input logic [31:0] er, input logic ei, input string nm);
        exp_t e;
        io_addr = a;
        io_wr = w;
        io_wdata = wd;
        chk = c;
        if (c) begin
            e.nm = nm;
            e.rd = er;
            e.irq = ei;
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        io_wr = 1'b0;
        chk = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] er, input logic ei, input string nm);
        cyc(a, 1'b0, 32'h0, 1'b1, er, ei, nm);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cyc(a, 1'b1, d, 1'b0, 32'h0, 1'b0, "");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "");
    endtask

    initial begin
        resetn = 1'b0;
        one = 4'h0;
        two = 4'h0;
        key = 4'hF;
        io_addr = 8'h00;
        io_wr = 1'b0;
        io_wdata = 32'h0;
        chk = 1'b0;
        @(posedge clock);
        #1;
        idle(1);
        resetn = 1'b1;
        rd(8'h00, 32'h0, 1'b0, "rst_one");
        rd(8'h04, 32'h0, 1'b0, "rst_two");
        rd(8'h08, 32'h0, 1'b0, "rst_key");
        rd(8'h0C, 32'h0, 1'b0, "rst_cap");
        rd(8'h10, 32'h0, 1'b0, "rst_mask");
        rd(8'h14, 32'h0, 1'b0, "rst_other");
        // switch debounce latency: new value visible only after the 6th edge
        one = 4'hA;
        two = 4'h3;
        for (int i = 0; i < 7; i++) rd(8'h00, i < 6 ? 32'h0 : 32'hA, 1'b0, "sw_latency");
        rd(8'h04, 32'h3, 1'b0, "sw_two");
        // 3-cycle glitch must be filtered out
        one = 4'h5;
        for (int i = 0; i < 3; i++) rd(8'h00, 32'hA, 1'b0, "sw_glitch");
        one = 4'hA;
        for (int i = 0; i < 6; i++) rd(8'h00, 32'hA, 1'b0, "sw_glitch_after");
        // key press capture with mask enabled
        wr(8'h10, 32'h4);
        key = 4'hB;
        for (int i = 0; i < 7; i++)
            rd(8'h0C, i < 6 ? 32'h0 : 32'h4, i < 6 ? 1'b0 : 1'b1, "key_capture");
        rd(8'h08, 32'h4, 1'b1, "key_pressed");
        rd(8'h10, 32'h4, 1'b1, "key_mask");
        key = 4'hF;
        idle(8);
        rd(8'h0C, 32'h4, 1'b1, "key_release_cap");
        rd(8'h08, 32'h0, 1'b1, "key_released");
        // write-1-to-clear
        cyc(8'h0C, 1'b1, 32'h4, 1'b1, 32'h4, 1'b1, "w1c_pre");
        rd(8'h0C, 32'h0, 1'b0, "w1c_clear");
        cyc(8'h0C, 1'b1, 32'h4, 1'b1, 32'h0, 1'b0, "w1c_again_pre");
        rd(8'h0C, 32'h0, 1'b0, "w1c_again");
        // press and clear on the same edge: set wins
        key = 4'hE;
        idle(5);
        cyc(8'h0C, 1'b1, 32'h1, 1'b1, 32'h0, 1'b0, "collide_pre");
        rd(8'h0C, 32'h1, 1'b0, "collide_set");
        key = 4'hF;
        idle(8);
        wr(8'h0C, 32'h1);
        rd(8'h0C, 32'h0, 1'b0, "collide_cleanup");
        // mask gating
        wr(8'h10, 32'h0);
        key = 4'hC;
        idle(8);
        rd(8'h0C, 32'h3, 1'b0, "gate_cap_masked");
        key = 4'hF;
        idle(8);
        cyc(8'h10, 1'b1, 32'h2, 1'b1, 32'h0, 1'b0, "gate_pre");
        rd(8'h10, 32'h2, 1'b1, "gate_irq");
        wr(8'h14, 32'hF);
        rd(8'h10, 32'h2, 1'b1, "ignored_wr_mask");
        rd(8'h0C, 32'h3, 1'b1, "ignored_wr_cap");
        // reset mid-debounce: key held low re-debounces from scratch after release
        key = 4'hD;
        idle(3);
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
        for (int i = 0; i < 7; i++) rd(8'h0C, i < 6 ? 32'h0 : 32'h2, 1'b0, "rst_mid_cap");
        rd(8'h10, 32'h0, 1'b0, "rst_mid_mask");
        rd(8'h08, 32'h2, 1'b0, "rst_mid_key");
        rd(8'h00, 32'hA, 1'b0, "post_one");
        rd(8'h04, 32'h3, 1'b0, "post_two");
        rd(8'h01, 32'h0, 1'b0, "unmapped");
        key = 4'hF;
        idle(1);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
